// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// master drives the ID/EX observations; slave is the hazard unit itself.
interface hazard_unit_if #(
  parameter int STALL_CNT_W = 16
);
  logic [5:0]             id_opcode;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   ex_mem_read;
  logic [4:0]             ex_rd;
  logic                   ex_div;
  logic                   branch_taken;
  logic                   hazard;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   div_busy;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_div, branch_taken,
    input  hazard, pc_write, ifid_write, ifid_flush, idex_flush, div_busy, stall_cycles
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_div, branch_taken,
    output hazard, pc_write, ifid_write, ifid_flush, idex_flush, div_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard detector: load-use stall, multi-cycle DIV hold, taken-branch
// flush, plus a saturating count of bubble cycles.
module hazard_unit #(
  parameter int DIV_CYCLES  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   rs_used, rt_used, lu, div_stall;
  logic                   hazard_c;

  // Which source fields the ID opcode actually reads.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    if (bus.id_opcode >= 6'd1 && bus.id_opcode <= 6'd11 &&
        bus.id_opcode != 6'd7 && bus.id_opcode != 6'd5)
      rs_used = 1'b1;
    if (bus.id_opcode == 6'd1 || bus.id_opcode == 6'd6 ||
        bus.id_opcode == 6'd9 || bus.id_opcode == 6'd11)
      rt_used = 1'b1;
  end

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
              (((bus.ex_rd == bus.id_rs) && rs_used) ||
               ((bus.ex_rd == bus.id_rt) && rt_used));

  // The entry cycle stalls combinationally, before the FSM has moved to BUSY.
  assign div_stall = ((state == IDLE) && bus.ex_div) || (state == BUSY);

  // DIV hold FSM next-state: count down the remaining EX occupancy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.ex_div && (DIV_CYCLES > 1)) begin
        cnt_n   = CNT_LOAD;
        state_n = BUSY;
      end
      BUSY: begin
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pipeline control resolution; DIV hold outranks branch, branch masks load-use.
  always_comb begin
    hazard_c        = 1'b0;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    if (reset_n) begin
      if (div_stall || (!bus.branch_taken && lu)) begin
        hazard_c       = 1'b1;
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
      end else if (bus.branch_taken) begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end
    end
  end

  // FSM state, countdown and saturating bubble counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (hazard_c && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.hazard       = hazard_c;
  assign bus.div_busy     = (state == BUSY);
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expectations queued per step, checked at negedge.
module tb_hazard_unit;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  hazard_unit_if #(.STALL_CNT_W(16)) bus ();

  hazard_unit #(.DIV_CYCLES(4), .STALL_CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        hz;
    logic        fl;
    logic        busy;
    logic [15:0] st;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] rd, input logic dv, input logic br);
    bus.id_opcode    = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.ex_mem_read  = mr;
    bus.ex_rd        = rd;
    bus.ex_div       = dv;
    bus.branch_taken = br;
  endtask

  // Queue the expectation, compare before the next edge, then let the edge happen.
  task automatic step(input string tag, input logic hz, input logic fl,
                      input logic busy, input logic [15:0] st);
    exp_t e, o;
    e.tag = tag; e.hz = hz; e.fl = fl; e.busy = busy; e.st = st;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({o.tag, "_hazard"},     16'(bus.hazard),     16'(o.hz));
    chk({o.tag, "_pc_write"},   16'(bus.pc_write),   16'(!o.hz));
    chk({o.tag, "_ifid_write"}, 16'(bus.ifid_write), 16'(!o.hz));
    chk({o.tag, "_ifid_flush"}, 16'(bus.ifid_flush), 16'(o.fl));
    chk({o.tag, "_idex_flush"}, 16'(bus.idex_flush), 16'(o.fl));
    chk({o.tag, "_div_busy"},   16'(bus.div_busy),   16'(o.busy));
    chk({o.tag, "_stall"},      bus.stall_cycles,    o.st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(6'd1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0); // load-use pattern held in reset
    @(posedge clk);
    #1;
    step("rst",        0, 0, 0, 16'd0);
    reset_n = 1'b1;
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("idle",       0, 0, 0, 16'd0);
    set_in(6'd1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    step("lu_rt",      1, 0, 0, 16'd0);
    set_in(6'd1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step("lu_after",   0, 0, 0, 16'd1);
    set_in(6'd5, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    step("lui_rs",     0, 0, 0, 16'd1);
    set_in(6'd1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("rd_zero",    0, 0, 0, 16'd1);
    set_in(6'd63, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    step("undef_op",   0, 0, 0, 16'd1);
    set_in(6'd2, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    step("lu_rs",      1, 0, 0, 16'd1);
    set_in(6'd2, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    step("rt_unused",  0, 0, 0, 16'd2);
    set_in(6'd1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1);
    step("br_lu",      0, 1, 0, 16'd2);
    // DIV hold of four cycles, with a branch and a repeated ex_div inside it
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("div_t0",     1, 0, 0, 16'd2);
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("div_t1_br",  1, 0, 1, 16'd3);
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("div_t2",     1, 0, 1, 16'd4);
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("div_t3",     1, 0, 1, 16'd5);
    step("div_done",   0, 0, 0, 16'd6);
    // reset in the middle of a DIV hold
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("rdiv_t0",    1, 0, 0, 16'd6);
    set_in(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("rdiv_t1",    1, 0, 1, 16'd7);
    reset_n = 1'b0;
    step("rdiv_rst",   0, 0, 1, 16'd8);
    reset_n = 1'b1;
    step("rdiv_rel",   0, 0, 0, 16'd0);
    step("rdiv_quiet", 0, 0, 0, 16'd0);
    // saturation of the bubble counter
    set_in(6'd1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    step("sat",        1, 0, 0, 16'hFFFF);
    step("sat_hold",   1, 0, 0, 16'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
